// File: rtl/ads131_frame_buffer.sv
// ADC frame buffer: serialises enabled channels of one frame into a FWFT FIFO.
// Ports: system_clock/reset_n, flush, ch_mask, in_valid/in_ready/frame_data,
//        out_valid/out_ready/out_data/out_ch/out_sof, level, ovf_count.
module ads131_frame_buffer #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 24,
    parameter int OUT_W    = 32,
    parameter int DEPTH    = 16,
    parameter int SIGN_EXT = 1
) (
    input  logic                       system_clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   frame_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [2:0]                 out_ch,
    output logic                       out_sof,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                ovf_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int WW = 1 + 3 + OUT_W;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_idx;
    logic                      r_sof_pend;
    logic [7:0]                r_mask;
    logic [NUM_CH*DATA_W-1:0]  r_frame;
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [LW-1:0]             r_level;
    logic [15:0]               r_ovf;
    logic [WW-1:0]             r_mem [DEPTH];

    logic [3:0]                w_n;
    logic                      w_fits;
    logic                      w_accept;
    logic                      w_drop;
    logic                      w_wr;
    logic                      w_pop;
    logic [DATA_W-1:0]         w_sample;
    logic [OUT_W-1:0]          w_ext;
    logic [WW-1:0]             w_head;

    // Number of channels the incoming frame would occupy
    always_comb begin
        w_n = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_n = w_n + 4'(ch_mask[c]);
        end
    end

    assign w_fits = (32'(DEPTH) - 32'(r_level)) >= 32'(w_n);

    // FSM next state and per-cycle control
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_wr        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid && !flush && (w_n != 4'd0)) begin
                    if (w_fits) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_wr = r_mask[r_idx] && !flush;
                if (r_idx == 3'(NUM_CH - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Channel select and width extension of the sample being written
    always_comb begin
        w_sample = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_idx == 3'(c)) begin
                w_sample = r_frame[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        if (SIGN_EXT != 0) begin
            w_ext = OUT_W'($signed(w_sample));
        end else begin
            w_ext = OUT_W'(w_sample);
        end
    end

    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_sof_pend <= 1'b0;
            r_mask     <= '0;
            r_frame    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_ovf      <= '0;
        end else if (flush) begin
            r_idx      <= '0;
            r_sof_pend <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
        end else begin
            if (w_accept) begin
                r_frame    <= frame_data;
                r_mask     <= 8'(ch_mask);
                r_idx      <= '0;
                r_sof_pend <= 1'b1;
            end else if (r_state == S_WRITE) begin
                r_idx <= r_idx + 3'd1;
                if (w_wr) begin
                    r_sof_pend <= 1'b0;
                end
            end
            if (w_drop && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_level <= r_level + LW'(w_wr) - LW'(w_pop);
        end
    end

    // Storage needs no reset: reads are masked while level is zero
    always_ff @(posedge system_clock) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {r_sof_pend, r_idx, w_ext};
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign out_data  = out_valid ? w_head[OUT_W-1:0] : '0;
    assign out_ch    = out_valid ? w_head[OUT_W+2:OUT_W] : '0;
    assign out_sof   = out_valid ? w_head[WW-1] : 1'b0;
    assign in_ready  = (r_state == S_IDLE) && reset_n;
    assign level     = r_level;
    assign ovf_count = r_ovf;

endmodule

// File: tb/tb_ads131_frame_buffer.sv
// Testbench for ads131_frame_buffer: directed and random frames checked
// against a queue-based reference model of the stored sample stream.
module tb_ads131_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  mask = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] frame = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_ch;
    logic        out_sof;
    logic [4:0]  level;
    logic [15:0] ovf_count;

    ads131_frame_buffer dut (
        .system_clock (clk),
        .reset_n      (rst_n),
        .flush        (flush),
        .ch_mask      (mask),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frame_data   (frame),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_sof      (out_sof),
        .level        (level),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          m_ovf = 0;
    int          maxlvl = 0;
    logic [35:0] q[$];
    bit          rnd_rdy = 1'b0;
    logic        rdy_fixed = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [23:0] s);
        return s[23] ? {8'hFF, s} : {8'h00, s};
    endfunction

    always @(posedge clk) begin
        #2;
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Reference model: a frame becomes an ordered list of tagged words at accept
    always @(negedge clk) begin : mon
        bit          first;
        logic [35:0] e;
        if (int'(level) > maxlvl) maxlvl = int'(level);
        if (!rst_n) begin
            q.delete();
            m_ovf = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (in_valid && in_ready && ($countones(mask) != 0)) begin
                if (16 - q.size() < $countones(mask)) begin
                    if (m_ovf < 65535) m_ovf++;
                end else begin
                    first = 1'b1;
                    for (int c = 0; c < 4; c++) begin
                        if (mask[c]) begin
                            q.push_back({first, 3'(c), ext(frame[c*24 +: 24])});
                            first = 1'b0;
                        end
                    end
                end
            end
            if (out_valid && out_ready) begin
                chk("pop_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    n_pop++;
                    chk("pop_ch", 64'(out_ch), 64'(e[34:32]));
                    chk("pop_data", 64'(out_data), 64'(e[31:0]));
                    chk("pop_sof", 64'(out_sof), 64'(e[35]));
                end
            end
        end
    end

    task automatic send(input logic [95:0] f, input logic [3:0] m);
        int k;
        in_valid = 1'b1;
        frame = f;
        mask = m;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("send_timeout", 64'(k < 200), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (level == '0 && in_ready) break;
        end
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_model", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] rnd_frame();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        int p0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(ovf_count), 64'd0);
        chk("rst_out_data", 64'({out_data, out_ch, out_sof}), 64'd0);
        cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        cycles(1);

        // T1: single full frame, streaming out
        rdy_fixed = 1'b1;
        cycles(1);
        p0 = n_pop;
        send({24'h123456, 24'h000001, 24'h800000, 24'h7FFFFF}, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_busy", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        chk("t1_idle", 64'(in_ready), 64'd1);
        drain();
        chk("t1_pops", 64'(n_pop - p0), 64'd4);

        // T2: sparse mask, consumer stalled
        rdy_fixed = 1'b0;
        cycles(1);
        for (int i = 0; i < 4; i++) send(rnd_frame(), 4'b1010);
        cycles(5);
        chk("t2_level", 64'(level), 64'd8);
        chk("t2_head_ch", 64'(out_ch), 64'd1);
        chk("t2_head_sof", 64'(out_sof), 64'd1);
        rdy_fixed = 1'b1;
        drain();

        // T3: fill to exactly DEPTH, then one dropped frame
        rdy_fixed = 1'b0;
        cycles(1);
        for (int i = 0; i < 4; i++) send(rnd_frame(), 4'hF);
        cycles(5);
        chk("t3_full", 64'(level), 64'd16);
        send(rnd_frame(), 4'hF);
        cycles(2);
        chk("t3_ovf", 64'(ovf_count), 64'd1);
        chk("t3_level_hold", 64'(level), 64'd16);
        chk("t3_in_ready", 64'(in_ready), 64'd1);
        rdy_fixed = 1'b1;
        drain();

        // T4: back-to-back frames through pointer wrap
        maxlvl = 0;
        for (int i = 0; i < 12; i++) send(rnd_frame(), 4'hF);
        drain();
        chk("t4_maxlvl", 64'(maxlvl <= 2), 64'd1);
        chk("t4_ovf", 64'(ovf_count), 64'd1);

        // T5: flush in the middle of a frame write
        rdy_fixed = 1'b0;
        cycles(1);
        send(rnd_frame(), 4'b0001);
        cycles(2);
        send(rnd_frame(), 4'hF);
        cycles(2);
        flush = 1'b1;
        @(negedge clk);
        chk("t5_pre_level", 64'(level), 64'd3);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_ovf", 64'(ovf_count), 64'd1);
        cycles(1);
        rdy_fixed = 1'b1;
        send(rnd_frame(), 4'hF);
        drain();

        // T6: asynchronous reset mid-write
        rdy_fixed = 1'b0;
        cycles(1);
        send(rnd_frame(), 4'hF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_in_ready", 64'(in_ready), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_ovf", 64'(ovf_count), 64'd0);
        chk("t6_out_data", 64'({out_data, out_ch, out_sof}), 64'd0);
        cycles(2);
        rst_n = 1'b1;
        rdy_fixed = 1'b1;
        cycles(1);
        send(rnd_frame(), 4'hF);
        drain();

        // T7: random masks, data and consumer back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(rnd_frame(), 4'($urandom_range(0, 15)));
        end
        rnd_rdy = 1'b0;
        rdy_fixed = 1'b1;
        drain();
        chk("t7_ovf", 64'(ovf_count), 64'(m_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
